aim_matcher_p: RTL and testbench



---
 rtl/aim_matcher_p_if.sv | 31 +++
 rtl/aim_matcher_p.sv | 198 +++++++++++++++++++
 tb/tb_aim_matcher_p.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/aim_matcher_p_if.sv
// Handshake and data bundle for the associative index matcher.
// The master side drives start, mode, chunk count, queries and the key array.
// The slave side (the matcher) returns busy, finish and per-query results.
interface aim_matcher_p_if #(
    parameter int N_QUERY    = 32,
    parameter int CHUNK      = 32,
    parameter int MAX_CHUNKS = 8,
    parameter int KEY_W      = 6,
    parameter int POS_W      = $clog2(CHUNK*MAX_CHUNKS),
    parameter int CNT_W      = $clog2(MAX_CHUNKS+1)
);
    logic                              i_start;
    logic                              i_mode;
    logic [CNT_W-1:0]                  i_num_chunks;
    logic [N_QUERY*KEY_W-1:0]          i_query;
    logic [CHUNK*MAX_CHUNKS*KEY_W-1:0] i_array;
    logic                              o_busy;
    logic                              o_finish;
    logic [N_QUERY-1:0]                o_valid;
    logic [N_QUERY*POS_W-1:0]          o_pos;

    modport master (
        output i_start, i_mode, i_num_chunks, i_query, i_array,
        input  o_busy, o_finish, o_valid, o_pos
    );

    modport slave (
        input  i_start, i_mode, i_num_chunks, i_query, i_array,
        output o_busy, o_finish, o_valid, o_pos
    );
endinterface

// File: rtl/aim_matcher_p.sv
// Parametrised associative index matcher.
// Scans the key array one chunk per cycle and, for every captured query,
// keeps either the first (lowest) or last (highest) matching flat position.
// Mode 0 stops early once every query has found a match.
module aim_matcher_p #(
    parameter int N_QUERY    = 32,
    parameter int CHUNK      = 32,
    parameter int MAX_CHUNKS = 8,
    parameter int KEY_W      = 6,
    parameter int POS_W      = $clog2(CHUNK*MAX_CHUNKS),
    parameter int CNT_W      = $clog2(MAX_CHUNKS+1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    aim_matcher_p_if.slave        io_bus
);

    localparam int DEPTH     = CHUNK * MAX_CHUNKS;
    localparam int ARR_W     = DEPTH * KEY_W;
    localparam int ARR_IDX_W = (ARR_W > 1) ? $clog2(ARR_W) : 1;
    localparam int IDX_W     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;

    logic [CNT_W-1:0]     r_chunk;
    logic [CNT_W-1:0]     r_numChunks;
    logic                 r_mode;
    logic [KEY_W-1:0]     r_query [N_QUERY];
    logic [N_QUERY-1:0]   r_valid;
    logic [POS_W-1:0]     r_pos   [N_QUERY];

    logic [CNT_W-1:0]     w_numClamped;
    logic [KEY_W-1:0]     w_entry [CHUNK];
    logic [CHUNK-1:0]     w_hit   [N_QUERY];
    logic [N_QUERY-1:0]   w_anyHit;
    logic [IDX_W-1:0]     w_lowIdx  [N_QUERY];
    logic [IDX_W-1:0]     w_highIdx [N_QUERY];
    logic [N_QUERY-1:0]   w_validNext;
    logic [POS_W-1:0]     w_posNext [N_QUERY];
    logic                 w_lastChunk;
    logic                 w_scanEnd;
    logic                 w_busy;
    logic                 w_finish;

    // Requests beyond the array depth are treated as a full-depth scan.
    assign w_numClamped = (io_bus.i_num_chunks > CNT_W'(MAX_CHUNKS)) ?
                          CNT_W'(MAX_CHUNKS) : io_bus.i_num_chunks;

    // Pick out the CHUNK entries of the chunk currently being scanned.
    always_comb begin
        logic [ARR_IDX_W-1:0] base;
        base = '0;
        for (int i = 0; i < CHUNK; i++) begin
            base       = ARR_IDX_W'((int'(r_chunk) * CHUNK + i) * KEY_W);
            w_entry[i] = io_bus.i_array[base +: KEY_W];
        end
    end

    // Per query: compare against the chunk and priority-encode lowest and highest hit.
    always_comb begin
        for (int q = 0; q < N_QUERY; q++) begin
            w_hit[q]     = '0;
            w_lowIdx[q]  = '0;
            w_highIdx[q] = '0;
            for (int i = 0; i < CHUNK; i++) begin
                w_hit[q][i] = (w_entry[i] == r_query[q]);
            end
            for (int i = CHUNK - 1; i >= 0; i--) begin
                if (w_hit[q][i]) begin
                    w_lowIdx[q] = IDX_W'(i);
                end
            end
            for (int i = 0; i < CHUNK; i++) begin
                if (w_hit[q][i]) begin
                    w_highIdx[q] = IDX_W'(i);
                end
            end
            w_anyHit[q] = |w_hit[q];
        end
    end

    // Result update: first-match keeps the earliest hit, last-match overwrites on every hit.
    always_comb begin
        w_validNext = r_valid;
        for (int q = 0; q < N_QUERY; q++) begin
            w_posNext[q] = r_pos[q];
        end
        for (int q = 0; q < N_QUERY; q++) begin
            if (w_anyHit[q]) begin
                if (r_mode) begin
                    w_validNext[q] = 1'b1;
                    w_posNext[q]   = POS_W'(int'(r_chunk) * CHUNK + int'(w_highIdx[q]));
                end else if (!r_valid[q]) begin
                    w_validNext[q] = 1'b1;
                    w_posNext[q]   = POS_W'(int'(r_chunk) * CHUNK + int'(w_lowIdx[q]));
                end
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake outputs; an empty scan goes straight to DONE.
    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        w_finish    = 1'b0;
        w_lastChunk = (r_chunk == (r_numChunks - CNT_W'(1)));
        w_scanEnd   = w_lastChunk || (!r_mode && (&w_validNext));
        case (r_state)
            IDLE: begin
                if (io_bus.i_start) begin
                    w_stateNext = (w_numClamped == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                w_busy = 1'b1;
                if (w_scanEnd) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_busy      = 1'b1;
                w_finish    = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath: capture the request on start, accumulate results while scanning.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chunk     <= '0;
            r_numChunks <= '0;
            r_mode      <= 1'b0;
            r_valid     <= '0;
            for (int q = 0; q < N_QUERY; q++) begin
                r_query[q] <= '0;
                r_pos[q]   <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.i_start) begin
                        r_chunk     <= '0;
                        r_numChunks <= w_numClamped;
                        r_mode      <= io_bus.i_mode;
                        r_valid     <= '0;
                        for (int q = 0; q < N_QUERY; q++) begin
                            r_query[q] <= io_bus.i_query[q*KEY_W +: KEY_W];
                            r_pos[q]   <= '0;
                        end
                    end
                end
                SCAN: begin
                    r_valid <= w_validNext;
                    for (int q = 0; q < N_QUERY; q++) begin
                        r_pos[q] <= w_posNext[q];
                    end
                    if (!w_scanEnd) begin
                        r_chunk <= r_chunk + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.o_busy   = w_busy;
    assign io_bus.o_finish = w_finish;
    assign io_bus.o_valid  = r_valid;

    genvar g;
    generate
        for (g = 0; g < N_QUERY; g++) begin : g_posOut
            assign io_bus.o_pos[g*POS_W +: POS_W] = r_pos[g];
        end
    endgenerate

endmodule

// File: tb/tb_aim_matcher_p.sv
// Self-checking bench for aim_matcher_p: directed cases plus randomized scans
// compared against a flat-array search model of first/last match and latency.
module tb_aim_matcher_p;

    localparam int N_QUERY    = 32;
    localparam int CHUNK      = 32;
    localparam int MAX_CHUNKS = 8;
    localparam int KEY_W      = 6;
    localparam int POS_W      = $clog2(CHUNK*MAX_CHUNKS);
    localparam int CNT_W      = $clog2(MAX_CHUNKS+1);
    localparam int DEPTH      = CHUNK * MAX_CHUNKS;
    localparam int CW         = N_QUERY * POS_W;

    logic clk;
    logic rstN;

    int checks;
    int errors;

    logic [KEY_W-1:0] mQuery [N_QUERY];
    logic [KEY_W-1:0] mArray [DEPTH];

    aim_matcher_p_if #(
        .N_QUERY(N_QUERY), .CHUNK(CHUNK), .MAX_CHUNKS(MAX_CHUNKS),
        .KEY_W(KEY_W), .POS_W(POS_W), .CNT_W(CNT_W)
    ) bus ();

    aim_matcher_p #(
        .N_QUERY(N_QUERY), .CHUNK(CHUNK), .MAX_CHUNKS(MAX_CHUNKS),
        .KEY_W(KEY_W), .POS_W(POS_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .io_bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fillArray(input logic [KEY_W-1:0] val);
        for (int e = 0; e < DEPTH; e++) mArray[e] = val;
    endtask

    task automatic fillQueries(input logic [KEY_W-1:0] val);
        for (int q = 0; q < N_QUERY; q++) mQuery[q] = val;
    endtask

    // Reference: linear search over the first n*CHUNK entries of the flat array.
    task automatic modelScan(input logic mode, input int numChunks,
                             output logic [N_QUERY-1:0] ev, output logic [CW-1:0] ep,
                             output int lat);
        int n;
        int worstChunk;
        bit allFound;
        n = (numChunks > MAX_CHUNKS) ? MAX_CHUNKS : numChunks;
        ev = '0;
        ep = '0;
        worstChunk = 0;
        allFound = 1'b1;
        for (int q = 0; q < N_QUERY; q++) begin
            int found;
            found = -1;
            for (int e = 0; e < n * CHUNK; e++) begin
                if (mArray[e] == mQuery[q]) begin
                    if (mode || found < 0) found = e;
                end
            end
            if (found >= 0) begin
                ev[q] = 1'b1;
                ep[q*POS_W +: POS_W] = POS_W'(found);
                if (found / CHUNK > worstChunk) worstChunk = found / CHUNK;
            end else begin
                allFound = 1'b0;
            end
        end
        lat = n;
        if (!mode && n > 0 && allFound) lat = worstChunk + 1;
    endtask

    // Run one scan: drive start, optionally pepper i_start during the scan, check everything.
    task automatic applyStimulus(input logic mode, input int numChunks, input bit strayStarts, input string tag);
        logic [N_QUERY-1:0] ev;
        logic [CW-1:0]      ep;
        int                 lat;
        int                 cycles;
        modelScan(mode, numChunks, ev, ep, lat);
        @(negedge clk);
        for (int q = 0; q < N_QUERY; q++) bus.i_query[q*KEY_W +: KEY_W] = mQuery[q];
        for (int e = 0; e < DEPTH; e++) bus.i_array[e*KEY_W +: KEY_W] = mArray[e];
        bus.i_mode       = mode;
        bus.i_num_chunks = CNT_W'(numChunks);
        bus.i_start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = strayStarts;
        for (int q = 0; q < N_QUERY; q++) bus.i_query[q*KEY_W +: KEY_W] = KEY_W'($urandom);
        bus.i_mode       = ~mode;
        bus.i_num_chunks = CNT_W'($urandom_range(0, 15));
        cycles = 0;
        while (!bus.o_finish && cycles < 40) begin
            checkOutput({tag, "_busy"}, CW'(bus.o_busy), CW'(1));
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (strayStarts) bus.i_start = 1'($urandom_range(0, 1));
        end
        bus.i_start = strayStarts;
        checkOutput({tag, "_finishSeen"}, CW'(bus.o_finish), CW'(1));
        checkOutput({tag, "_latency"}, CW'(cycles), CW'(lat));
        checkOutput({tag, "_busyDone"}, CW'(bus.o_busy), CW'(1));
        checkOutput({tag, "_valid"}, CW'(bus.o_valid), CW'(ev));
        checkOutput({tag, "_pos"}, bus.o_pos, ep);
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        checkOutput({tag, "_finishPulse"}, CW'(bus.o_finish), CW'(0));
        checkOutput({tag, "_idle"}, CW'(bus.o_busy), CW'(0));
        checkOutput({tag, "_validHeld"}, CW'(bus.o_valid), CW'(ev));
        checkOutput({tag, "_posHeld"}, bus.o_pos, ep);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstN = 1'b0;
        bus.i_start = 1'b0;
        bus.i_mode = 1'b0;
        bus.i_num_chunks = '0;
        bus.i_query = '0;
        bus.i_array = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", CW'(bus.o_busy), CW'(0));
        checkOutput("rst_finish", CW'(bus.o_finish), CW'(0));
        checkOutput("rst_valid", CW'(bus.o_valid), CW'(0));
        checkOutput("rst_pos", bus.o_pos, CW'(0));
        rstN = 1'b1;
        @(negedge clk);
        $display("[TB] reset released");

        // First/last match with one absent query.
        fillArray(KEY_W'(0));
        fillQueries(KEY_W'(62));
        mQuery[0] = KEY_W'(5);
        mQuery[1] = KEY_W'(63);
        mArray[2] = KEY_W'(5);
        mArray[40] = KEY_W'(5);
        applyStimulus(1'b0, 3, 1'b0, "t1_first");
        applyStimulus(1'b1, 3, 1'b0, "t2_last");

        // Early termination when every query hits in chunk 0.
        fillArray(KEY_W'(0));
        fillQueries(KEY_W'(7));
        mArray[1] = KEY_W'(7);
        applyStimulus(1'b0, 8, 1'b0, "t3_early");
        applyStimulus(1'b1, 8, 1'b0, "t3_full");

        // Empty scan and clamped count.
        applyStimulus(1'b0, 0, 1'b0, "t4_zero");
        applyStimulus(1'b1, 12, 1'b0, "t4_clamp");

        // Last array entry reachable only with the full chunk count.
        fillArray(KEY_W'(0));
        fillQueries(KEY_W'(62));
        mQuery[0] = KEY_W'(9);
        mArray[DEPTH-1] = KEY_W'(9);
        applyStimulus(1'b0, 8, 1'b0, "t5_top");
        applyStimulus(1'b0, 7, 1'b0, "t5_short");

        // Stray start pulses during the scan and during DONE.
        fillArray(KEY_W'(0));
        fillQueries(KEY_W'(62));
        mQuery[0] = KEY_W'(5);
        mArray[2] = KEY_W'(5);
        mArray[40] = KEY_W'(5);
        applyStimulus(1'b1, 5, 1'b1, "t6_stray");

        // Reset while chunk 2 is being scanned.
        @(negedge clk);
        for (int q = 0; q < N_QUERY; q++) bus.i_query[q*KEY_W +: KEY_W] = mQuery[q];
        for (int e = 0; e < DEPTH; e++) bus.i_array[e*KEY_W +: KEY_W] = mArray[e];
        bus.i_mode = 1'b1;
        bus.i_num_chunks = CNT_W'(8);
        bus.i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_busy", CW'(bus.o_busy), CW'(0));
        checkOutput("midrst_finish", CW'(bus.o_finish), CW'(0));
        checkOutput("midrst_valid", CW'(bus.o_valid), CW'(0));
        checkOutput("midrst_pos", bus.o_pos, CW'(0));
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 3, 1'b0, "t6_recover");

        // Randomized scans.
        for (int t = 0; t < 24; t++) begin
            logic m;
            int   n;
            m = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 10);
            for (int e = 0; e < DEPTH; e++) mArray[e] = KEY_W'($urandom_range(0, (t % 3 == 0) ? 31 : 63));
            for (int q = 0; q < N_QUERY; q++) begin
                if (t % 2 == 1) mQuery[q] = mArray[$urandom_range(0, CHUNK * 2 - 1)];
                else            mQuery[q] = KEY_W'($urandom_range(0, 63));
            end
            applyStimulus(m, n, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
